div_iter_unit: RTL and testbench

- Multicycle restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock.
- Sits beside the ALU in the execute stage and drives the team's 32-bit adder_sub in subtract mode (Mode=1) as its trial subtractor; consumes result/Cout each cycle.
- The control FSM holds the multicycle sequencer in its execute state while busy is high, and latches result when done pulses.

---
 rtl/div_pkg.sv | 8 +
 rtl/adder_sub.sv | 15 +
 rtl/div_step.sv | 29 ++
 rtl/div_iter_unit.sv | 128 ++++++++++++
 tb/tb_div_iter_unit.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
package div_pkg;
  localparam int XLEN      = 32;
  localparam int DIV_STEPS = 32;

  typedef enum logic [1:0] {DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11} div_op_e;
  typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, FIX = 2'b10} div_state_e;
endpackage

// File: rtl/adder_sub.sv
// Ripple adder/subtractor: mode=1 computes a-b, cout=1 means no borrow.
module adder_sub #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         mode,
  output logic [W-1:0] result,
  output logic         cout
);
  logic [W-1:0] b_eff;

  assign b_eff          = b ^ {W{mode}};
  assign {cout, result} = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, mode};
endmodule

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, select.
module div_step
  import div_pkg::*;
(
  input  logic [XLEN-1:0] r,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] r_next,
  output logic            take
);
  logic [XLEN-1:0] t;
  logic [XLEN-1:0] diff;
  logic            cout;

  // R stays below 2^31 between steps, so the shifted value fits in XLEN bits.
  assign t = {r[XLEN-2:0], q[XLEN-1]};

  adder_sub #(.W(XLEN)) u_sub (
    .a     (t),
    .b     (dvs),
    .mode  (1'b1),
    .result(diff),
    .cout  (cout)
  );

  // take doubles as the quotient bit shifted into Q.
  assign take   = cout;
  assign r_next = cout ? diff : t;
endmodule

// File: rtl/div_iter_unit.sv
// Multicycle restoring divider for DIV/DIVU/REM/REMU, one quotient bit per clock.
module div_iter_unit
  import div_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  div_state_e      state_q, state_d;
  div_op_e         op_q, op_d;
  logic            qneg_q, qneg_d, rneg_q, rneg_d;
  logic [XLEN-1:0] q_q, q_d, r_q, r_d, dvs_q, dvs_d, result_q, result_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            done_q, done_d;

  logic            sgn, a_neg, b_neg, step_take;
  logic [XLEN-1:0] a_mag, b_mag, r_next;

  div_step u_step (
    .r     (r_q),
    .q     (q_q),
    .dvs   (dvs_q),
    .r_next(r_next),
    .take  (step_take)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    q_d      = q_q;
    r_d      = r_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;

    sgn   = (div_op_e'(op) == DIV) || (div_op_e'(op) == REM);
    a_neg = sgn & dividend[XLEN-1];
    b_neg = sgn & divisor[XLEN-1];
    a_mag = a_neg ? (~dividend + 1'b1) : dividend;
    b_mag = b_neg ? (~divisor + 1'b1) : divisor;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d = div_op_e'(op);
          if (divisor == '0) begin
            result_d = (op[1] == 1'b0) ? '1 : dividend;
            done_d   = 1'b1;
          end else if (sgn && dividend == {1'b1, {(XLEN-1){1'b0}}} && divisor == '1) begin
            result_d = (div_op_e'(op) == DIV) ? {1'b1, {(XLEN-1){1'b0}}} : '0;
            done_d   = 1'b1;
          end else begin
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            q_d     = a_mag;
            r_d     = '0;
            dvs_d   = b_mag;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          q_d   = {q_q[XLEN-2:0], step_take};
          r_d   = r_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(DIV_STEPS - 1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!abort) begin
          case (op_q)
            DIV:     result_d = qneg_q ? (~q_q + 1'b1) : q_q;
            DIVU:    result_d = q_q;
            REM:     result_d = rneg_q ? (~r_q + 1'b1) : r_q;
            default: result_d = r_q;
          endcase
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= DIV;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      q_q      <= '0;
      r_q      <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      q_q      <= q_d;
      r_q      <= r_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;
endmodule

// File: tb/tb_div_iter_unit.sv
// Scoreboard bench for div_iter_unit: directed cases plus randomized ops against an arithmetic model.
module tb_div_iter_unit;
  import div_pkg::*;

  logic        clk, rst_n, start, abort, busy, done;
  logic [1:0]  op;
  logic [31:0] dividend, divisor, result;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          c0;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          total = 0, bad = 0, cyc = 0;
  logic [31:0] last_exp = '0;

  div_iter_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .dividend(dividend),
    .divisor (divisor),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference: plain RV32M semantics on 64-bit signed integers.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb2;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    case (o)
      2'd0:    return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb2);
      2'd1:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd2:    return (b == 0) ? a : 32'(sa % sb2);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 1;
    if (o[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  task automatic do_op(input bit now, input bit push, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b);
    int n;
    exp_t x;
    if (!now) @(negedge clk);
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("busy_timeout", 32'(busy), 32'd0);
    start    = 1'b1;
    op       = o;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      x.res = model(o, a, b);
      x.lat = model_lat(o, a, b);
      x.c0  = cyc;
      sb.push_back(x);
      last_exp = x.res;
    end
  endtask

  task automatic wait_done(output int nb);
    bit found;
    found = 0;
    nb    = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1;
      else if (busy) nb++;
    end
    if (!found) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int nb;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; op = '0; dividend = '0; divisor = '0;

    fork
      forever begin
        @(negedge clk);
        if (rst_n && done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("result", result, e.res);
            chk("latency", 32'(cyc - e.c0 + 1), 32'(e.lat));
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    rst_n = 1'b1;

    do_op(0, 1, DIVU, 100, 7);   wait_done(nb);  chk("busy_cycles", 32'(nb), 32'd33);
    do_op(0, 1, REMU, 100, 7);   wait_done(nb);
    do_op(0, 1, DIV, 32'hFFFF_FFF9, 2); wait_done(nb);
    do_op(0, 1, REM, 32'hFFFF_FFF9, 2); wait_done(nb);
    do_op(0, 1, REM, 7, 32'hFFFF_FFFE); wait_done(nb);
    do_op(0, 1, DIVU, 5, 0);     wait_done(nb);  chk("div0_busy", 32'(nb), 32'd0);
    do_op(0, 1, REMU, 5, 0);     wait_done(nb);
    do_op(0, 1, DIV, 32'h8000_0000, 32'hFFFF_FFFF);  wait_done(nb); chk("ovf_busy", 32'(nb), 32'd0);
    do_op(0, 1, REM, 32'h8000_0000, 32'hFFFF_FFFF);  wait_done(nb);
    do_op(0, 1, DIVU, 32'h8000_0000, 32'hFFFF_FFFF); wait_done(nb);
    do_op(0, 1, DIVU, 32'hFFFF_FFFF, 32'h8000_0001); wait_done(nb);
    do_op(0, 1, REMU, 32'hFFFF_FFFF, 32'h8000_0001); wait_done(nb);
    chk("done_cycle_busy", 32'(busy), 32'd0);
    do_op(1, 1, DIVU, 9, 3);     wait_done(nb);

    // Start pulses while busy must be dropped.
    do_op(0, 1, DIVU, 1000, 10);
    for (int k = 0; k < 3; k++) begin
      repeat (5) @(negedge clk);
      start = 1'b1; op = REMU; dividend = 77 + k; divisor = 1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(nb);

    // Abort mid-CALC: no done, result keeps the previous value.
    do_op(0, 0, DIVU, 12345, 6);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    chk("abort_result", result, last_exp);

    // Async reset mid-CALC clears everything at once.
    do_op(0, 0, DIVU, 500, 7);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 150; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 0;
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2:       rb = $urandom_range(1, 15);
        3:       rb = 32'hFFFF_FFFF - $urandom_range(0, 3);
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      do_op(0, 1, ro, ra, rb);
    end

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) chk("drain", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
